// File: rtl/tl_arb_pkg.sv
`default_nettype none
// tl_arb_pkg -- state encodings, index type and TileLink-UL constants for the boot-ROM arbiter.
// Rev 1.0
package tl_arb_pkg;

  localparam logic [1:0] S_IDLE_ENC = 2'd0;
  localparam logic [1:0] S_A_ENC    = 2'd1;
  localparam logic [1:0] S_D_ENC    = 2'd2;
  localparam logic [1:0] S_TO_ENC   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = S_IDLE_ENC,
    S_A    = S_A_ENC,
    S_D    = S_D_ENC,
    S_TO   = S_TO_ENC
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam int TL_AW   = 32;
  localparam int TL_DW   = 32;
  localparam int TL_MW   = TL_DW / 8;
  localparam int TL_SZW  = 3;
  localparam int TL_SRCW = 4;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

endpackage
`default_nettype wire

// File: rtl/tl_arb_watchdog.sv
`default_nettype none
// tl_arb_watchdog -- response watchdog; expire is high on the last permitted wait cycle.
// Rev 1.0
module tl_arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  generate
    if (TIMEOUT != 0) begin : g_wd_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
      assign expire = (cnt == LAST);
    end else begin : g_wd_off
      assign expire = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tl_rom_arbiter.sv
`default_nettype none
// tl_rom_arbiter -- 2:1 round-robin TileLink-UL arbiter in front of the boot ROM, one transaction in flight.
// Rev 1.0
module tl_rom_arbiter
  import tl_arb_pkg::*;
#(
  parameter int PRIO_INIT = 0,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  // requester 0 (fetch)
  input  logic               m0_a_valid,
  output logic               m0_a_ready,
  input  logic [2:0]         m0_a_opcode,
  input  logic [2:0]         m0_a_param,
  input  logic [TL_SZW-1:0]  m0_a_size,
  input  logic [TL_SRCW-1:0] m0_a_source,
  input  logic [TL_AW-1:0]   m0_a_address,
  input  logic [TL_MW-1:0]   m0_a_mask,
  input  logic [TL_DW-1:0]   m0_a_data,
  input  logic               m0_a_corrupt,
  output logic               m0_d_valid,
  input  logic               m0_d_ready,
  output logic [2:0]         m0_d_opcode,
  output logic [2:0]         m0_d_param,
  output logic [TL_SZW-1:0]  m0_d_size,
  output logic [TL_SRCW-1:0] m0_d_source,
  output logic               m0_d_denied,
  output logic [TL_DW-1:0]   m0_d_data,
  output logic               m0_d_corrupt,
  // requester 1 (data)
  input  logic               m1_a_valid,
  output logic               m1_a_ready,
  input  logic [2:0]         m1_a_opcode,
  input  logic [2:0]         m1_a_param,
  input  logic [TL_SZW-1:0]  m1_a_size,
  input  logic [TL_SRCW-1:0] m1_a_source,
  input  logic [TL_AW-1:0]   m1_a_address,
  input  logic [TL_MW-1:0]   m1_a_mask,
  input  logic [TL_DW-1:0]   m1_a_data,
  input  logic               m1_a_corrupt,
  output logic               m1_d_valid,
  input  logic               m1_d_ready,
  output logic [2:0]         m1_d_opcode,
  output logic [2:0]         m1_d_param,
  output logic [TL_SZW-1:0]  m1_d_size,
  output logic [TL_SRCW-1:0] m1_d_source,
  output logic               m1_d_denied,
  output logic [TL_DW-1:0]   m1_d_data,
  output logic               m1_d_corrupt,
  // downstream ROM
  output logic               s_a_valid,
  input  logic               s_a_ready,
  output logic [2:0]         s_a_opcode,
  output logic [2:0]         s_a_param,
  output logic [TL_SZW-1:0]  s_a_size,
  output logic [TL_SRCW-1:0] s_a_source,
  output logic [TL_AW-1:0]   s_a_address,
  output logic [TL_MW-1:0]   s_a_mask,
  output logic [TL_DW-1:0]   s_a_data,
  output logic               s_a_corrupt,
  input  logic               s_d_valid,
  output logic               s_d_ready,
  input  logic [2:0]         s_d_opcode,
  input  logic [2:0]         s_d_param,
  input  logic [TL_SZW-1:0]  s_d_size,
  input  logic [TL_SRCW-1:0] s_d_source,
  input  logic               s_d_denied,
  input  logic [TL_DW-1:0]   s_d_data,
  input  logic               s_d_corrupt
);

  localparam mst_idx_t RR_INIT = mst_idx_t'(PRIO_INIT[0]);

  arb_state_t         state, state_nxt;
  mst_idx_t           gnt, gnt_nxt, rr, rr_nxt;
  logic [TL_SZW-1:0]  cap_size;
  logic [TL_SRCW-1:0] cap_source;
  logic               wd_clr, wd_en, wd_expire;
  logic               sel_a_valid, sel_d_ready;
  logic               a_ready_sel, d_valid_sel;
  logic [2:0]         d_opcode, d_param;
  logic [TL_SZW-1:0]  d_size;
  logic [TL_SRCW-1:0] d_source;
  logic               d_denied, d_corrupt;
  logic [TL_DW-1:0]   d_data;

  assign sel_a_valid = gnt ? m1_a_valid : m0_a_valid;
  assign sel_d_ready = gnt ? m1_d_ready : m0_d_ready;

  assign s_a_opcode  = gnt ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = gnt ? m1_a_param   : m0_a_param;
  assign s_a_size    = gnt ? m1_a_size    : m0_a_size;
  assign s_a_source  = gnt ? m1_a_source  : m0_a_source;
  assign s_a_address = gnt ? m1_a_address : m0_a_address;
  assign s_a_mask    = gnt ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = gnt ? m1_a_data    : m0_a_data;
  assign s_a_corrupt = gnt ? m1_a_corrupt : m0_a_corrupt;

  assign m0_a_ready = a_ready_sel & ~gnt;
  assign m1_a_ready = a_ready_sel &  gnt;
  assign m0_d_valid = d_valid_sel & ~gnt;
  assign m1_d_valid = d_valid_sel &  gnt;

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    rr_nxt      = rr;
    s_a_valid   = 1'b0;
    s_d_ready   = 1'b0;
    a_ready_sel = 1'b0;
    d_valid_sel = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    case (state)
      S_IDLE: begin
        s_d_ready = 1'b1;
        if (m0_a_valid || m1_a_valid) begin
          state_nxt = S_A;
          gnt_nxt   = (m0_a_valid && m1_a_valid) ? rr : mst_idx_t'(m1_a_valid);
        end
      end
      S_A: begin
        s_a_valid   = sel_a_valid;
        a_ready_sel = s_a_ready;
        if (sel_a_valid && s_a_ready) begin
          state_nxt = S_D;
          wd_clr    = 1'b1;
        end else if (!sel_a_valid) begin
          state_nxt = S_IDLE;
        end
      end
      S_D: begin
        s_d_ready   = sel_d_ready;
        d_valid_sel = s_d_valid;
        if (s_d_valid && sel_d_ready) begin
          state_nxt = S_IDLE;
          rr_nxt    = ~gnt;
        end else begin
          wd_en = 1'b1;
          if (wd_expire && !s_d_valid) state_nxt = S_TO;
        end
      end
      S_TO: begin
        s_d_ready   = 1'b1;
        d_valid_sel = 1'b1;
        if (sel_d_ready) begin
          state_nxt = S_IDLE;
          rr_nxt    = ~gnt;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Denied data responses also flag corrupt, as TileLink requires for AccessAckData.
  always_comb begin
    d_opcode  = s_d_opcode;
    d_param   = s_d_param;
    d_size    = s_d_size;
    d_source  = s_d_source;
    d_denied  = s_d_denied;
    d_data    = s_d_data;
    d_corrupt = s_d_corrupt;
    if (state == S_TO) begin
      d_opcode  = TL_ACCESS_ACK_DATA;
      d_param   = 3'd0;
      d_size    = cap_size;
      d_source  = cap_source;
      d_denied  = 1'b1;
      d_data    = '0;
      d_corrupt = 1'b1;
    end
  end

  assign m0_d_opcode  = d_opcode;
  assign m0_d_param   = d_param;
  assign m0_d_size    = d_size;
  assign m0_d_source  = d_source;
  assign m0_d_denied  = d_denied;
  assign m0_d_data    = d_data;
  assign m0_d_corrupt = d_corrupt;
  assign m1_d_opcode  = d_opcode;
  assign m1_d_param   = d_param;
  assign m1_d_size    = d_size;
  assign m1_d_source  = d_source;
  assign m1_d_denied  = d_denied;
  assign m1_d_data    = d_data;
  assign m1_d_corrupt = d_corrupt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gnt        <= 1'b0;
      rr         <= RR_INIT;
      cap_size   <= '0;
      cap_source <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      rr    <= rr_nxt;
      if (state == S_A && s_a_valid && s_a_ready) begin
        cap_size   <= s_a_size;
        cap_source <= s_a_source;
      end
    end
  end

  tl_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

endmodule
`default_nettype wire
